// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding used by both the transmit and
// receive paths, default frame/timing parameters and a bit-timing helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 87;

  // Clock cycles per serial bit for a given system clock and baud rate.
  function automatic int clks_per_bit(input int f_clk, input int baud);
    return f_clk / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// N-stage synchronizer for an asynchronous single-bit input. STAGES must be
// at least 2. All flops take RST_VAL on reset so an idle-high line does not
// look active while the chain refills.
module uart_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= {STAGES{RST_VAL}};
    else       r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_WIDTH data bits LSB-first, optional even
// parity bit (compile with UART_RX_PARITY_EN), one stop bit. Bits are sampled
// mid-bit and delivered through a valid/ready holding register, with
// framing-error, overrun and parity-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SERIAL_RX,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DOUT_VALID,
  input  logic                  DOUT_READY,
  output logic                  FRAME_ERR,
  output logic                  OVERRUN,
  output logic                  PARITY_ERR,
  output logic                  BUSY
);

  localparam int SYNC_STAGES = 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  logic                  w_rx_s;
  logic                  r_rx_q;
  logic [SYNC_STAGES:0]  r_live;
  uart_state_e           r_state;
  uart_state_e           w_next;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_valid;
  logic                  r_ferr;
  logic                  r_ovr;
  logic                  w_fall;
  logic                  w_cnt_bit;
  logic                  w_cnt_half;
  logic                  w_stop_smp;
  logic                  w_par_bad;

`ifdef UART_RX_PARITY_EN
  logic r_par;
  logic r_perr;
  assign w_par_bad  = ^{r_shift, r_par};
  assign PARITY_ERR = r_perr;
`else
  assign w_par_bad  = 1'b0;
  assign PARITY_ERR = 1'b0;
`endif

  uart_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (SERIAL_RX),
    .o_q   (w_rx_s)
  );

  // Delayed copy of the synchronized line for edge detection, plus a fill
  // marker: the reset value 1 in the synchronizer would otherwise make a line
  // held low out of reset look like a falling edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_q <= 1'b1;
      r_live <= '0;
    end else begin
      r_rx_q <= w_rx_s;
      r_live <= {r_live[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_fall     = r_live[SYNC_STAGES] & r_rx_q & ~w_rx_s;
  assign w_cnt_bit  = (r_cnt == CNT_BIT);
  assign w_cnt_half = (r_cnt == CNT_HALF);
  assign w_stop_smp = (r_state == STOP) && w_cnt_bit;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_fall) w_next = START;
      START:  if (w_cnt_half) w_next = w_rx_s ? IDLE : DATA;
      DATA: begin
        if (w_cnt_bit && (r_idx == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (w_cnt_bit) w_next = STOP;
`endif
      STOP:   if (w_cnt_bit) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    BUSY = (r_state != IDLE);
  end

  // Bit timing, bit index and sample capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      case (r_state)
        START: begin
          if (w_cnt_half) begin
            r_cnt <= '0;
            r_idx <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_cnt_bit) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx_s;
            if (r_idx != IDX_LAST) r_idx <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_cnt_bit) begin
            r_cnt <= '0;
            r_par <= w_rx_s;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_cnt_bit) r_cnt <= '0;
          else           r_cnt <= r_cnt + 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Holding register and error pulses; a faulty frame is dropped before the
  // overrun decision so it can never report an overrun.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
      if (r_valid && DOUT_READY) r_valid <= 1'b0;
      if (w_stop_smp) begin
        if (!w_rx_s || w_par_bad) begin
          r_ferr <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
          r_perr <= w_par_bad;
`endif
        end else if (!r_valid || DOUT_READY) begin
          r_dout  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end
    end
  end

  assign DOUT       = r_dout;
  assign DOUT_VALID = r_valid;
  assign FRAME_ERR  = r_ferr;
  assign OVERRUN    = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with a byte scoreboard. Also exercises the
// parity path when built with UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int DW  = 8;
  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 79 + CPB;
`else
  localparam int LAT = 79;
`endif

  logic          CLK        = 1'b0;
  logic          RST        = 1'b1;
  logic          SERIAL_RX  = 1'b1;
  logic          DOUT_READY = 1'b0;
  logic [DW-1:0] DOUT;
  logic          DOUT_VALID;
  logic          FRAME_ERR;
  logic          OVERRUN;
  logic          PARITY_ERR;
  logic          BUSY;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q[$];
  int n_deliv = 0, n_fe = 0, n_ov = 0, n_pe = 0, n_vcyc = 0, last_deliv_cyc = 0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0, prev_pe = 1'b0;
  logic [DW-1:0] prev_dout = '0;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SERIAL_RX  (SERIAL_RX),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .FRAME_ERR  (FRAME_ERR),
    .OVERRUN    (OVERRUN),
    .PARITY_ERR (PARITY_ERR),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drive one frame from just after a rising edge; line is left high.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_b);
    SERIAL_RX = 1'b0;
    cycles(CPB);
    for (int i = 0; i < DW; i++) begin
      SERIAL_RX = d[i];
      cycles(CPB);
    end
`ifdef UART_RX_PARITY_EN
    SERIAL_RX = (^d) ^ par_flip;
    cycles(CPB);
`endif
    SERIAL_RX = stop_b;
    cycles(CPB);
    SERIAL_RX = 1'b1;
  endtask

  // Output monitor: pops the scoreboard on each new delivery, counts pulses.
  always @(negedge CLK) begin
    if (!RST) begin
      if (DOUT_VALID) n_vcyc++;
      if (DOUT_VALID && !(prev_v && !prev_r)) begin
        n_deliv++;
        last_deliv_cyc = cyc;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_delivery: observed %0h expected none", DOUT);
        end
        if (exp_q.size() != 0) check("dout", 32'(DOUT), 32'(exp_q.pop_front()));
      end else if (DOUT_VALID && prev_v) begin
        check("dout_hold", 32'(DOUT), 32'(prev_dout));
      end
      if (FRAME_ERR) begin n_fe++; check("fe_width", 32'(prev_fe), 32'(0)); end
      if (OVERRUN) begin n_ov++; check("ov_width", 32'(prev_ov), 32'(0)); end
      if (PARITY_ERR) begin n_pe++; check("pe_width", 32'(prev_pe), 32'(0)); end
    end
    prev_v    = DOUT_VALID;
    prev_r    = DOUT_READY;
    prev_fe   = FRAME_ERR;
    prev_ov   = OVERRUN;
    prev_pe   = PARITY_ERR;
    prev_dout = DOUT;
  end

  initial begin
    int e0, d0, fe0, ov0, pe0;

    // Reset state
    RST = 1'b1;
    cycles(4);
    check("rst_dout", 32'(DOUT), 32'(0));
    check("rst_valid", 32'(DOUT_VALID), 32'(0));
    check("rst_ferr", 32'(FRAME_ERR), 32'(0));
    check("rst_ovr", 32'(OVERRUN), 32'(0));
    check("rst_perr", 32'(PARITY_ERR), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(0));
    RST = 1'b0;
    cycles(6);

    // Single frame, consumer always ready: latency and one-cycle valid
    DOUT_READY = 1'b1;
    exp_q.push_back(8'hA5);
    e0 = cyc;
    send_frame(8'hA5, 1'b1);
    cycles(4);
    check("latency", last_deliv_cyc - e0, LAT);
    check("deliv_a5", n_deliv, 1);
    check("valid_cycles", n_vcyc, 1);
    check("busy_after", 32'(BUSY), 32'(0));

    // Back-to-back frames with consumer stalled: overrun keeps first byte
    DOUT_READY = 1'b0;
    d0 = n_deliv; ov0 = n_ov; fe0 = n_fe;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    cycles(4);
    check("ovr_dout", 32'(DOUT), 32'h3C);
    check("ovr_valid", 32'(DOUT_VALID), 32'(1));
    check("ovr_count", n_ov, ov0 + 1);
    check("ovr_deliv", n_deliv, d0 + 1);
    check("ovr_no_fe", n_fe, fe0);
    DOUT_READY = 1'b1;
    cycles(1);
    check("ready_clears", 32'(DOUT_VALID), 32'(0));
    check("ready_dout_kept", 32'(DOUT), 32'h3C);

    // Stop bit low: framing error, byte dropped, then a good frame
    d0 = n_deliv; ov0 = n_ov; fe0 = n_fe;
    send_frame(8'h55, 1'b0);
    cycles(20);
    check("fe_count", n_fe, fe0 + 1);
    check("fe_no_deliv", n_deliv, d0);
    check("fe_valid", 32'(DOUT_VALID), 32'(0));
    check("fe_no_ovr", n_ov, ov0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    cycles(4);
    check("after_fe_deliv", n_deliv, d0 + 1);

    // Two-cycle start glitch
    d0 = n_deliv; ov0 = n_ov; fe0 = n_fe; pe0 = n_pe;
    SERIAL_RX = 1'b0;
    cycles(2);
    SERIAL_RX = 1'b1;
    cycles(2);
    check("glitch_busy", 32'(BUSY), 32'(1));
    cycles(10);
    check("glitch_idle", 32'(BUSY), 32'(0));
    check("glitch_no_deliv", n_deliv, d0);
    check("glitch_no_flags", n_fe + n_ov + n_pe, fe0 + ov0 + pe0);

    // Reset mid-data, release with line low, then idle, then a frame
    SERIAL_RX = 1'b0;
    cycles(CPB);
    SERIAL_RX = 1'b1;
    cycles(20);
    check("mid_data_busy", 32'(BUSY), 32'(1));
    RST = 1'b1;
    SERIAL_RX = 1'b0;
    cycles(3);
    RST = 1'b0;
    cycles(120);
    check("low_after_rst_busy", 32'(BUSY), 32'(0));
    SERIAL_RX = 1'b1;
    cycles(20);
    check("rst_abort_no_deliv", n_deliv, d0);
    check("rst_abort_no_fe", n_fe, fe0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    cycles(4);
    check("rst_then_81", n_deliv, d0 + 1);

`ifdef UART_RX_PARITY_EN
    // Parity accepted, then rejected
    d0 = n_deliv; pe0 = n_pe; fe0 = n_fe;
    par_flip = 1'b0;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    cycles(4);
    check("par_ok_deliv", n_deliv, d0 + 1);
    check("par_ok_no_pe", n_pe, pe0);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    cycles(4);
    par_flip = 1'b0;
    check("par_bad_pe", n_pe, pe0 + 1);
    check("par_bad_no_deliv", n_deliv, d0 + 1);
    check("par_bad_no_fe", n_fe, fe0);
`else
    check("perr_never", n_pe, 0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side counterpart to the UART transmitter: consumes an asynchronous 8N1-style serial line (one start bit, DATA_WIDTH data bits LSB-first, one stop bit).
- Recovers the bits by mid-bit oversampling and presents each byte through a valid/ready holding register.
- Flags framing errors and overruns.
- Sits between the board RX pin and the UART register/FIFO layer.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 87, CLK cycles per bit, computed as f_clk / baud; must be >= 4.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- SERIAL_RX  in  1  asynchronous serial line; idles high.
- DOUT  out  DATA_WIDTH  received byte; stable while DOUT_VALID=1.
- DOUT_VALID  out  1  holding register full.
- DOUT_READY  in  1  consumer accepts DOUT when DOUT_VALID & DOUT_READY.
- FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low.
- OVERRUN  out  1  one-cycle pulse: byte completed while the holding register was full and not being read.
- PARITY_ERR  out  1  one-cycle pulse on parity mismatch; tied 0 when the parity feature is compiled out.
- BUSY  out  1  FSM not in IDLE.

Behaviour:
- Reset:
  - Synchronizer flops = 1, state=IDLE, counters=0.
  - DOUT=0; DOUT_VALID, FRAME_ERR, OVERRUN, PARITY_ERR and BUSY all 0.
  - Reset mid-frame abandons the frame silently.
- Input path:
  - 2-FF synchronizer on SERIAL_RX, giving rx_s.
  - rx_q is rx_s delayed one cycle; used for edge detection.
- Counters:
  - Bit-clock counter width $clog2(CLKS_PER_BIT).
  - Bit index width $clog2(DATA_WIDTH).
  - No wrap beyond the stated limits.
- IDLE:
  - A start is detected only on a falling edge (rx_q=1, rx_s=0), so a line held low out of reset is ignored until it returns high.
  - On the edge: counter=0, go to START.
- START:
  - Count to (CLKS_PER_BIT-1)/2, the mid start bit.
  - If rx_s=0: counter=0, index=0, go to DATA.
  - If rx_s=1: glitch; return to IDLE with no flags.
- DATA:
  - Each time the counter reaches CLKS_PER_BIT-1: sample rx_s into shift[index] and reset the counter.
  - After index DATA_WIDTH-1 is sampled, go to STOP (or PARITY when the feature is enabled).
- STOP:
  - At counter = CLKS_PER_BIT-1, i.e. mid stop bit, sample rx_s and go to IDLE in the same cycle, so the next start edge can be caught half a bit early.
  - Stop=1: deliver the byte (see below).
  - Stop=0: FRAME_ERR pulses the next cycle, the byte is discarded, and DOUT/DOUT_VALID are unchanged.
- Delivery (registered; DOUT_VALID and DOUT update the cycle after the stop sample):
  - Holding register empty, or DOUT_READY=1 that cycle: load DOUT and set DOUT_VALID=1.
  - Holding register full and DOUT_READY=0: new byte dropped, old DOUT kept, OVERRUN pulses.
  - DOUT_READY with no new byte: DOUT_VALID clears next cycle; DOUT holds its last value.
- Error priority: a frame with a framing error never raises OVERRUN.
- Latency: from the SERIAL_RX falling edge to DOUT_VALID = 3 + (CLKS_PER_BIT-1)/2 + (DATA_WIDTH+1)*CLKS_PER_BIT + 1 cycles. Exact count is checked in the test plan.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY after DATA: one extra bit period, sampled mid-bit.
  - Even parity: XOR of data bits and parity bit must be 0.
  - On mismatch, PARITY_ERR pulses the cycle after the stop sample and the byte is discarded (no delivery, no OVERRUN).
  - A frame with both faults raises FRAME_ERR and PARITY_ERR together.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state; PARITY_ERR tied 0.

Decomposition:
- Package uart_pkg:
  - state enum shared by tx/rx (IDLE, START, DATA, PARITY, STOP).
  - Default DATA_WIDTH/CLKS_PER_BIT localparams.
  - Function clks_per_bit(f_clk, baud).
- Sub-module uart_sync: parameterised N-stage synchronizer (default 2, reset value 1), reusable for other async inputs.

Test Plan (CLKS_PER_BIT=8, DATA_WIDTH=8 unless noted; stimulus from a bench-driven bit-timed model):
- Frame 0xA5, DOUT_READY=1:
  - DOUT=0xA5 with DOUT_VALID high for exactly 1 cycle.
  - Exactly 3+3+72+1=79 cycles after the falling edge; BUSY low afterwards.
- Two back-to-back frames 0x3C, 0xC3 with DOUT_READY=0, then READY=1:
  - After frame 1: DOUT=0x3C.
  - Frame 2: OVERRUN pulses once and DOUT stays 0x3C.
  - READY: DOUT_VALID clears.
- Frame 0x55 with stop bit forced low:
  - FRAME_ERR 1-cycle pulse, DOUT_VALID stays 0.
  - Next good frame 0x12 is received correctly.
- Start glitch low for 2 cycles:
  - Returns to IDLE, no flags, no DOUT_VALID.
- RST asserted mid-DATA of 0xFF, released with line low, then high, then frame 0x81:
  - Nothing delivered for the aborted frame.
  - Only 0x81 is delivered.
- UART_RX_PARITY_EN defined:
  - Frame 0x07 with parity bit 1 is accepted.
  - Same frame with parity bit 0: PARITY_ERR pulses, no DOUT_VALID.
